// File: rtl/r22_bf2i_sdf_if.sv
// Streaming sample interface for the radix-2^2 BF2I SDF stage.
// Carries one complex sample {re, im} per valid cycle into the stage, and
// the stage's output sample plus its sync / -j select flags out of it.
// master: the upstream producer / downstream consumer side (drives in_*).
// slave:  the butterfly stage itself (drives out_*).
interface r22_bf2i_sdf_if #(
    parameter int DATA_W = 11
);
    logic                  in_valid;
    logic                  in_sync;
    logic [2*DATA_W-1:0]   in_data;
    logic                  out_valid;
    logic                  out_sync;
    logic                  out_jsel;
    logic [2*DATA_W-1:0]   out_data;

    modport master (
        output in_valid,
        output in_sync,
        output in_data,
        input  out_valid,
        input  out_sync,
        input  out_jsel,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_sync,
        input  in_data,
        output out_valid,
        output out_sync,
        output out_jsel,
        output out_data
    );
endinterface

// File: rtl/r22_bf2i_sdf.sv
// Radix-2^2 single-path delay-feedback butterfly stage BF2I.
// A frame is 2*DELAY samples. During the first half (FILL) incoming samples
// enter the feedback line while the previous frame's differences leave it.
// During the second half (BFLY) the half-scaled sum goes out and the
// half-scaled difference goes back into the line. out_jsel flags the
// samples the downstream -j stage must rotate.
// Optional build macro BF2I_ROUND_EN: add 1 before the >>1 (round half up)
// on both sum and difference; otherwise plain floor truncation.
module r22_bf2i_sdf #(
    parameter int DATA_W = 11,
    parameter int DELAY  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    r22_bf2i_sdf_if.slave bus
);
    // Phase counter width: counts 0 .. 2*DELAY-1 and wraps naturally
    // because DELAY is a power of two.
    localparam int CW = $clog2(2 * DELAY);
    localparam int SW = 2 * DATA_W;
    localparam logic [CW-1:0] SUM_START = CW'(DELAY);

`ifdef BF2I_ROUND_EN
    localparam logic signed [DATA_W+1:0] RND = (DATA_W + 2)'(1);
`else
    localparam logic signed [DATA_W+1:0] RND = '0;
`endif

    // Phase state
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_eff;
    logic [CW-1:0] cnt_next;
    logic          fill;
    logic          jsel_next;
    logic          sync_next;

    // Datapath
    logic [SW-1:0] line_reg [DELAY];
    logic [SW-1:0] d_word;
    logic [SW-1:0] x_word;
    logic [SW-1:0] sum_word;
    logic [SW-1:0] dif_word;
    logic [SW-1:0] line_in;
    logic [SW-1:0] data_next;

    // Registered outputs
    logic          valid_reg;
    logic          sync_reg;
    logic          jsel_reg;
    logic [SW-1:0] data_reg;

    assign x_word = bus.in_data;
    assign d_word = line_reg[DELAY-1];

    // Phase decode: a qualified sync restarts the frame at this very sample.
    always_comb begin
        cnt_eff   = cnt_reg;
        if (bus.in_valid && bus.in_sync) begin
            cnt_eff = '0;
        end
        cnt_next  = cnt_eff + CW'(1);
        fill      = ~cnt_eff[CW-1];
        jsel_next = fill & cnt_eff[CW-2];
        sync_next = (cnt_eff == SUM_START);
    end

    // Per-component half-scaled butterfly. Component 0 is im (low half),
    // component 1 is re (high half). Two guard bits keep the sum exact
    // before the shift; only the low DATA_W bits of the shifted value remain.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_comp
        logic signed [DATA_W+1:0] d_ext;
        logic signed [DATA_W+1:0] x_ext;
        logic signed [DATA_W+1:0] sum_ext;
        logic signed [DATA_W+1:0] dif_ext;

        assign d_ext   = {{2{d_word[gi*DATA_W+DATA_W-1]}}, d_word[gi*DATA_W +: DATA_W]};
        assign x_ext   = {{2{x_word[gi*DATA_W+DATA_W-1]}}, x_word[gi*DATA_W +: DATA_W]};
        assign sum_ext = d_ext + x_ext + RND;
        assign dif_ext = d_ext - x_ext + RND;

        assign sum_word[gi*DATA_W +: DATA_W] = DATA_W'(sum_ext >>> 1);
        assign dif_word[gi*DATA_W +: DATA_W] = DATA_W'(dif_ext >>> 1);
    end

    // FILL: new sample goes into the line, old difference comes out.
    // BFLY: difference goes back into the line, sum comes out.
    always_comb begin
        line_in   = dif_word;
        data_next = sum_word;
        if (fill) begin
            line_in   = x_word;
            data_next = d_word;
        end
    end

    // Feedback delay line: shifts one place per valid sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) begin
                line_reg[i] <= '0;
            end
        end else if (bus.in_valid) begin
            line_reg[0] <= line_in;
            for (int i = 1; i < DELAY; i++) begin
                line_reg[i] <= line_reg[i-1];
            end
        end
    end

    // Phase counter and output registers; flags and data hold between valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
            sync_reg  <= 1'b0;
            jsel_reg  <= 1'b0;
            data_reg  <= '0;
        end else begin
            valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                cnt_reg  <= cnt_next;
                sync_reg <= sync_next;
                jsel_reg <= jsel_next;
                data_reg <= data_next;
            end
        end
    end

    assign bus.out_valid = valid_reg;
    assign bus.out_sync  = sync_reg;
    assign bus.out_jsel  = jsel_reg;
    assign bus.out_data  = data_reg;

endmodule
